serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
// - Serial frame transmitter, the transmit end of the team's single-wire serial byte link.
// - Accepts one byte over a valid/ready handshake and drives it onto an idle-high line.
// - Frame order: start bit (0), DATA_W data bits, odd-parity bit, stop bit(s) (1).
// - Feeds the serialDP receiver; a loopback of tx_out into serialDP must produce done with out_byte == tx_data.
// PARAMETERS
// - DATA_W      8  data bits per frame
// - MSB_FIRST   1  1: data[DATA_W-1] is sent first (matches receiver shift-left assembly); 0: LSB first
// - BIT_CYCLES  1  clk cycles per serial bit, >=1
// - STOP_LEN    1  number of stop bits, >=1
// - IDLE_GAP    0  minimum extra idle-high bits between frames
// PORTS
// - clk           in   1       clock; all logic on posedge
// - reset         in   1       synchronous, active-high
// - tx_data       in   DATA_W  byte to send; sampled only on handshake
// - tx_valid      in   1       tx_data is valid
// - tx_ready      out  1       transmitter can accept a byte this cycle
// - bad_parity    in   1       test hook: sampled on handshake; 1 inverts the parity bit of that frame
// - tx_out        out  1       serial line, registered, idle 1
// - busy          out  1       frame in progress (START..STOP/GAP)
// - frame_done    out  1       1-cycle pulse in the final cycle of the last stop bit
// BEHAVIOUR
// - Reset, and every cycle it is held: tx_out=1, tx_ready=0, busy=0, frame_done=0, state=IDLE.
//   Counters clear. Reset mid-frame aborts the frame immediately; the line returns high next cycle.
// - tx_ready is 1 in IDLE from the cycle after reset deasserts.
// - Handshake: accept when tx_valid && tx_ready.
//   - Latch tx_data into a shift register.
//   - Latch parity = ~^tx_data ^ bad_parity, so data+parity ones-count is odd.
//   - tx_data and bad_parity are ignored at all other times.
// - FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
//   - IDLE -(handshake)-> START
//   - START -> DATA
//   - DATA -(DATA_W bits sent)-> PARITY
//   - PARITY -> STOP
//   - STOP -(STOP_LEN bits sent)-> GAP if IDLE_GAP>0, else IDLE
//   - GAP -(IDLE_GAP bits)-> IDLE
// - Each state/bit lasts exactly BIT_CYCLES cycles, timed by a bit-cycle counter; bit index counts bits sent.
// - tx_out per state: START=0; DATA=current shift bit; PARITY=latched parity; STOP=1; GAP=1; IDLE=1.
// - Latency: a handshake in cycle k puts the start bit on tx_out at cycle k+1.
// - Frame length: (1+DATA_W+1+STOP_LEN)*BIT_CYCLES cycles.
// - Back-to-back, IDLE_GAP=0: tx_ready also asserts in the final cycle of the last stop bit.
//   A handshake there goes straight to START, giving a contiguous stream with no extra idle bit.
// - tx_ready=0 in START/DATA/PARITY/GAP and in all non-final STOP cycles.
//   tx_valid held high while tx_ready=0 is not consumed; the data must be held stable until accepted.
// - busy=1 from the start bit through the last STOP/GAP cycle.
//   busy=0 in IDLE, including the cycle of the handshake.
// - frame_done fires once per frame, including frames sent with bad_parity.
// TESTING
// - Reset, then idle 20 cycles -> tx_out=1, busy=0, tx_ready=1, frame_done never pulses.
// - Send 0xA5, defaults -> tx_out = 0,1,0,1,0,0,1,0,1,1,1; frame_done in the 11th cycle.
//   Loopback into serialDP yields done with out_byte=0xA5.
// - Send 0x01 then 0xFF back-to-back -> parity bits 0 then 1.
//   22 contiguous cycles; the second start bit directly follows the first stop bit.
// - BIT_CYCLES=4, STOP_LEN=2, IDLE_GAP=1, send 0x00 -> each bit held 4 cycles, parity=1.
//   8 cycles high for the stop bits, 4-cycle gap, then tx_ready=1.
// - bad_parity=1 with 0xA5 -> parity bit 0; serialDP loopback gives no done.
//   A following clean 0x3C is received correctly.
// - Assert reset during DATA bit 4 -> next cycle tx_out=1, busy=0.
//   A new handshake after reset sends a complete, correct frame.

Source files
------------

// File: rtl/serial_frame_tx_if.sv
// Byte handshake bundle for serial_frame_tx: valid/ready plus data and the parity test hook.
// The master drives a byte and the transmitter (slave) answers with ready.
interface serial_frame_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              bad_parity;

    modport master (
        output tx_data,
        output tx_valid,
        output bad_parity,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  bad_parity,
        output tx_ready
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits, odd parity, stop bit(s), optional gap.
// The line is registered and idles high; one byte is accepted per frame over a valid/ready handshake.
module serial_frame_tx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned STOP_LEN   = 1,
    parameter int unsigned IDLE_GAP   = 0
) (
    input  logic                clk,
    input  logic                reset,
    serial_frame_tx_if.slave    tx_if,
    output logic                tx_out,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned CycW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned MaxCnt = (DATA_W > STOP_LEN) ?
                                     ((DATA_W > IDLE_GAP) ? DATA_W : IDLE_GAP) :
                                     ((STOP_LEN > IDLE_GAP) ? STOP_LEN : IDLE_GAP);
    localparam int unsigned IdxW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
    localparam int unsigned GapN   = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

    localparam logic [CycW-1:0] CycLast  = CycW'(BIT_CYCLES - 1);
    localparam logic [IdxW-1:0] DataLast = IdxW'(DATA_W - 1);
    localparam logic [IdxW-1:0] StopLast = IdxW'(STOP_LEN - 1);
    localparam logic [IdxW-1:0] GapLast  = IdxW'(GapN);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StGap
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [CycW-1:0]     r_cyc;
    logic [CycW-1:0]     w_cyc_d;
    logic [IdxW-1:0]     r_idx;
    logic [IdxW-1:0]     w_idx_d;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_d;
    logic                r_parity;
    logic                w_parity_d;
    logic                r_tx_out;
    logic                w_tx_out_d;

    logic                w_bit_end;
    logic                w_stop_last;
    logic                w_ready;
    logic                w_accept;
    logic                w_cur_bit;

    assign w_bit_end   = (r_cyc == CycLast);
    assign w_stop_last = (r_state == StStop) && w_bit_end && (r_idx == StopLast);

    // With no gap, the final stop cycle doubles as an accept slot for a seamless stream.
    assign w_ready  = !reset && ((r_state == StIdle) || (w_stop_last && (IDLE_GAP == 0)));
    assign w_accept = tx_if.tx_valid && w_ready;

    always_comb begin
        w_state_d  = r_state;
        w_cyc_d    = w_bit_end ? '0 : r_cyc + 1'b1;
        w_idx_d    = r_idx;
        w_shift_d  = r_shift;
        w_parity_d = r_parity;

        case (r_state)
            StIdle: begin
                w_cyc_d = '0;
                w_idx_d = '0;
                if (w_accept) begin
                    w_state_d  = StStart;
                    w_shift_d  = tx_if.tx_data;
                    w_parity_d = ~^tx_if.tx_data ^ tx_if.bad_parity;
                end
            end
            StStart: begin
                if (w_bit_end) begin
                    w_state_d = StData;
                    w_idx_d   = '0;
                end
            end
            StData: begin
                if (w_bit_end) begin
                    if (r_idx == DataLast) begin
                        w_state_d = StParity;
                        w_idx_d   = '0;
                    end else begin
                        w_idx_d   = r_idx + 1'b1;
                        w_shift_d = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
                    end
                end
            end
            StParity: begin
                if (w_bit_end) begin
                    w_state_d = StStop;
                    w_idx_d   = '0;
                end
            end
            StStop: begin
                if (w_bit_end) begin
                    if (r_idx == StopLast) begin
                        w_idx_d = '0;
                        if (w_accept) begin
                            w_state_d  = StStart;
                            w_shift_d  = tx_if.tx_data;
                            w_parity_d = ~^tx_if.tx_data ^ tx_if.bad_parity;
                        end else if (IDLE_GAP > 0) begin
                            w_state_d = StGap;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end else begin
                        w_idx_d = r_idx + 1'b1;
                    end
                end
            end
            StGap: begin
                if (w_bit_end) begin
                    if (r_idx == GapLast) begin
                        w_state_d = StIdle;
                        w_idx_d   = '0;
                    end else begin
                        w_idx_d = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cyc_d   = '0;
                w_idx_d   = '0;
            end
        endcase
    end

    // The line value is derived from next-state so the start bit appears the cycle after accept.
    assign w_cur_bit = (MSB_FIRST != 0) ? w_shift_d[DATA_W-1] : w_shift_d[0];

    always_comb begin
        w_tx_out_d = 1'b1;
        case (w_state_d)
            StStart:  w_tx_out_d = 1'b0;
            StData:   w_tx_out_d = w_cur_bit;
            StParity: w_tx_out_d = w_parity_d;
            default:  w_tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_cyc    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx_out <= 1'b1;
        end else begin
            r_state  <= w_state_d;
            r_cyc    <= w_cyc_d;
            r_idx    <= w_idx_d;
            r_shift  <= w_shift_d;
            r_parity <= w_parity_d;
            r_tx_out <= w_tx_out_d;
        end
    end

    assign tx_if.tx_ready = w_ready;
    assign tx_out         = r_tx_out;
    assign busy           = !reset && (r_state != StIdle);
    assign frame_done     = !reset && w_stop_last;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: table-driven frame waveforms plus hand-written corner sequences,
// with a line decoder on the default instance checking received bytes against a scoreboard.
module tb_serial_frame_tx;

    logic clk = 1'b0;
    logic reset0;
    logic reset1;
    logic tx_out0, busy0, fd0;
    logic tx_out1, busy1, fd1;

    int total = 0;
    int bad   = 0;

    logic [8:0] sb_q[$];

    typedef struct {
        logic [7:0]  data;
        logic        bad;
        logic [10:0] line;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    serial_frame_tx_if #(.DATA_W(8)) if0 ();
    serial_frame_tx_if #(.DATA_W(8)) if1 ();

    serial_frame_tx dut0 (
        .clk        (clk),
        .reset      (reset0),
        .tx_if      (if0.slave),
        .tx_out     (tx_out0),
        .busy       (busy0),
        .frame_done (fd0)
    );

    serial_frame_tx #(
        .BIT_CYCLES (4),
        .STOP_LEN   (2),
        .IDLE_GAP   (1)
    ) dut1 (
        .clk        (clk),
        .reset      (reset1),
        .tx_if      (if1.slave),
        .tx_out     (tx_out1),
        .busy       (busy1),
        .frame_done (fd1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame decoder for the BIT_CYCLES=1 instance, standing in for the receiver.
    initial begin
        int         cnt;
        logic [7:0] rx;
        logic       par;
        logic [8:0] e;
        logic       par_ok;
        logic       exp_ok;
        cnt = 0;
        rx  = '0;
        par = 1'b0;
        forever begin
            @(negedge clk);
            if (reset0 !== 1'b0) begin
                cnt = 0;
            end else if (cnt == 0) begin
                if (tx_out0 === 1'b0) cnt = 1;
            end else if (cnt <= 8) begin
                rx  = {rx[6:0], tx_out0};
                cnt = cnt + 1;
            end else if (cnt == 9) begin
                par = tx_out0;
                cnt = 10;
            end else begin
                if (sb_q.size() == 0) begin
                    chk("rx_unexpected_frame", 32'(rx), 32'hFFFF_FFFF);
                end else begin
                    e      = sb_q.pop_front();
                    par_ok = ^{rx, par};
                    exp_ok = !e[8];
                    chk("rx_byte", 32'(rx), 32'(e[7:0]));
                    chk("rx_parity_ok", 32'(par_ok), 32'(exp_ok));
                    chk("rx_stop", 32'(tx_out0), 32'd1);
                end
                cnt = 0;
            end
        end
    end

    task automatic send_vec(input vec_t v);
        int   waitc;
        logic exp_fd;
        waitc = 0;
        @(negedge clk);
        if0.tx_data    = v.data;
        if0.bad_parity = v.bad;
        if0.tx_valid   = 1'b1;
        while (if0.tx_ready !== 1'b1 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        chk("ready_before_send", 32'(if0.tx_ready), 32'd1);
        sb_q.push_back({v.bad, v.data});
        @(posedge clk);
        #1;
        if0.tx_valid   = 1'b0;
        if0.tx_data    = 8'($urandom);
        if0.bad_parity = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            exp_fd = (i == 10);
            chk("line_bit", 32'(tx_out0), 32'(v.line[10-i]));
            chk("busy_in_frame", 32'(busy0), 32'd1);
            chk("frame_done", 32'(fd0), 32'(exp_fd));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] line_a;
        logic [10:0] line_b;
        logic        exp_b;
        logic        exp_r;
        logic        exp_o;

        vecs[0] = '{data: 8'hA5, bad: 1'b0, line: 11'b0_10100101_1_1};
        vecs[1] = '{data: 8'hA5, bad: 1'b1, line: 11'b0_10100101_0_1};
        vecs[2] = '{data: 8'h3C, bad: 1'b0, line: 11'b0_00111100_1_1};
        vecs[3] = '{data: 8'h80, bad: 1'b0, line: 11'b0_10000000_0_1};
        vecs[4] = '{data: 8'h00, bad: 1'b0, line: 11'b0_00000000_1_1};

        reset0 = 1'b1;
        reset1 = 1'b1;
        if0.tx_valid = 1'b0; if0.tx_data = '0; if0.bad_parity = 1'b0;
        if1.tx_valid = 1'b0; if1.tx_data = '0; if1.bad_parity = 1'b0;

        // Outputs while reset is held; a valid request must not be taken.
        if0.tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx_out", 32'(tx_out0), 32'd1);
            chk("rst_ready", 32'(if0.tx_ready), 32'd0);
            chk("rst_busy", 32'(busy0), 32'd0);
            chk("rst_done", 32'(fd0), 32'd0);
        end
        if0.tx_valid = 1'b0;
        reset0 = 1'b0;
        reset1 = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_tx_out", 32'(tx_out0), 32'd1);
            chk("idle_busy", 32'(busy0), 32'd0);
            chk("idle_ready", 32'(if0.tx_ready), 32'd1);
            chk("idle_done", 32'(fd0), 32'd0);
            chk("idle1_tx_out", 32'(tx_out1), 32'd1);
            chk("idle1_ready", 32'(if1.tx_ready), 32'd1);
        end

        for (int i = 0; i < 5; i++) send_vec(vecs[i]);

        // Back-to-back 0x01 then 0xFF with valid held throughout.
        line_a = 11'b0_00000001_0_1;
        line_b = 11'b0_11111111_1_1;
        @(negedge clk);
        if0.tx_data = 8'h01; if0.bad_parity = 1'b0; if0.tx_valid = 1'b1;
        chk("b2b_ready0", 32'(if0.tx_ready), 32'd1);
        sb_q.push_back({1'b0, 8'h01});
        @(posedge clk);
        #1;
        if0.tx_data = 8'hFF;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            exp_r = (i == 10);
            chk("b2b_line_a", 32'(tx_out0), 32'(line_a[10-i]));
            chk("b2b_ready_a", 32'(if0.tx_ready), 32'(exp_r));
            if (i == 10 && if0.tx_ready === 1'b1) sb_q.push_back({1'b0, 8'hFF});
        end
        @(posedge clk);
        #1;
        if0.tx_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            exp_b = (i == 10);
            chk("b2b_line_b", 32'(tx_out0), 32'(line_b[10-i]));
            chk("b2b_done_b", 32'(fd0), 32'(exp_b));
        end

        // Slow instance: 4 cycles/bit, two stop bits, one gap bit, byte 0x00.
        @(negedge clk);
        if1.tx_data = 8'h00; if1.bad_parity = 1'b0; if1.tx_valid = 1'b1;
        chk("slow_ready0", 32'(if1.tx_ready), 32'd1);
        @(posedge clk);
        #1;
        if1.tx_valid = 1'b0;
        for (int c = 1; c <= 53; c++) begin
            @(negedge clk);
            exp_o = (c > 36);
            exp_b = (c <= 52);
            exp_r = (c == 53);
            chk("slow_line", 32'(tx_out1), 32'(exp_o));
            chk("slow_busy", 32'(busy1), 32'(exp_b));
            chk("slow_ready", 32'(if1.tx_ready), 32'(exp_r));
            chk("slow_done", 32'(fd1), 32'(c == 48));
        end

        // Reset during data bit index 4 of 0xA5.
        @(negedge clk);
        if0.tx_data = 8'hA5; if0.bad_parity = 1'b0; if0.tx_valid = 1'b1;
        chk("abort_ready0", 32'(if0.tx_ready), 32'd1);
        sb_q.push_back({1'b0, 8'hA5});
        @(posedge clk);
        #1;
        if0.tx_valid = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        chk("abort_bit4", 32'(tx_out0), 32'd0);
        reset0 = 1'b1;
        @(negedge clk);
        chk("abort_tx_out", 32'(tx_out0), 32'd1);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_ready", 32'(if0.tx_ready), 32'd0);
        chk("abort_done", 32'(fd0), 32'd0);
        @(negedge clk);
        void'(sb_q.pop_back());
        reset0 = 1'b0;
        @(negedge clk);
        chk("post_abort_ready", 32'(if0.tx_ready), 32'd1);
        chk("post_abort_line", 32'(tx_out0), 32'd1);
        send_vec(vecs[0]);

        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
